// File: rtl/ahb_bram_bridge.sv
// rtl/ahb_bram_bridge.sv - AHB-Lite slave to simple dual-port BRAM bridge
// Optional build macro: BRAM_RAW_FWD_EN (read-after-write forwarding instead of a stall cycle)
module ahb_bram_bridge #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

`ifdef BRAM_RAW_FWD_EN
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_ERR1, S_ERR2, S_STALL} state_t;
`endif

  state_t                  state_q, state_d;
  logic                    hreadyout_q, hreadyout_d;
  logic                    hresp_q, hresp_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              mask_q, mask_d;
`ifdef BRAM_RAW_FWD_EN
  logic [31:0]             wdata_q, wdata_d;
  logic                    fwd_q, fwd_d;
`endif

  logic                    accept;
  logic                    unaligned;
  logic                    hazard;
  logic [3:0]              mask_nxt;
  logic [ADDR_WIDTH-1:0]   haddr_word;
  logic                    unused_ok;

  assign unused_ok  = &{1'b0, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};
  assign haddr_word = HADDR[ADDR_WIDTH+1:2];
  assign accept     = HSEL & HTRANS[1] & HREADY;
  assign unaligned  = ((HSIZE == 3'd1) && HADDR[0]) ||
                      ((HSIZE >= 3'd2) && (HADDR[1:0] != 2'b00));
  // The RAM samples port B at the same edge the pending write lands, so it returns stale data.
  assign hazard     = (state_q == S_WR) && (haddr_word == addr_q);

  always_comb begin
    mask_nxt = 4'b1111;
    case (HSIZE)
      3'd0:    mask_nxt = 4'b0001 << HADDR[1:0];
      3'd1:    mask_nxt = 4'b0011 << HADDR[1:0];
      default: mask_nxt = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
`ifdef BRAM_RAW_FWD_EN
    fwd_d   = 1'b0;
    wdata_d = (state_q == S_WR) ? HWDATA : wdata_q;
`endif
    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
`ifndef BRAM_RAW_FWD_EN
    end else if (state_q == S_STALL) begin
      state_d = S_RD;
`endif
    end else if (!accept) begin
      state_d = S_IDLE;
    end else if (unaligned) begin
      state_d = S_ERR1;
    end else begin
      addr_d = haddr_word;
      if (HWRITE) begin
        state_d = S_WR;
        mask_d  = mask_nxt;
      end else begin
`ifdef BRAM_RAW_FWD_EN
        state_d = S_RD;
        fwd_d   = hazard;
`else
        state_d = hazard ? S_STALL : S_RD;
`endif
      end
    end

    hreadyout_d = (state_d != S_ERR1);
`ifndef BRAM_RAW_FWD_EN
    if (state_d == S_STALL) hreadyout_d = 1'b0;
`endif
    hresp_d = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      addr_q      <= '0;
      mask_q      <= '0;
`ifdef BRAM_RAW_FWD_EN
      wdata_q     <= '0;
      fwd_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
`ifdef BRAM_RAW_FWD_EN
      wdata_q     <= wdata_d;
      fwd_q       <= fwd_d;
`endif
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign ram_wea   = (state_q == S_WR) ? mask_q : 4'b0000;
  assign ram_addra = addr_q;
  assign ram_dina  = HWDATA;
`ifdef BRAM_RAW_FWD_EN
  assign ram_addrb = haddr_word;
`else
  assign ram_addrb = (state_q == S_STALL) ? addr_q : haddr_word;
`endif

  always_comb begin
    HRDATA = 32'h0;
    if (state_q == S_RD) begin
      for (int i = 0; i < 4; i++) begin
`ifdef BRAM_RAW_FWD_EN
        HRDATA[8*i +: 8] = (fwd_q && mask_q[i]) ? wdata_q[8*i +: 8] : ram_doutb[8*i +: 8];
`else
        HRDATA[8*i +: 8] = ram_doutb[8*i +: 8];
`endif
      end
    end
  end

endmodule

// File: tb/tb_ahb_bram_bridge.sv
// tb/tb_ahb_bram_bridge.sv - directed self-checking bench for ahb_bram_bridge with a BRAM model
module tb_ahb_bram_bridge;
  localparam int AW = 14;

  logic          HCLK = 1'b0;
  logic          HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0]   HADDR, HWDATA, HRDATA, ram_dina, ram_doutb;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [3:0]    ram_wea;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  int            n_chk = 0;
  int            n_pass = 0;
  int            waits;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_bram_bridge #(.ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  always @(posedge HCLK) begin
    if (load_en) mem[load_addr] <= load_data;
    for (int i = 0; i < 4; i++)
      if (ram_wea[i]) mem[ram_addra][8*i +: 8] <= ram_dina[8*i +: 8];
    ram_doutb <= mem[ram_addrb];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic bus(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size;
  endtask

  task automatic idle;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; HSIZE = 3'd2;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    load_addr = a; load_data = d; load_en = 1'b1;
    step;
    load_en = 1'b0;
  endtask

  initial begin
    HRESETn = 1'b0; HWDATA = 32'h0; load_en = 1'b0; load_addr = '0; load_data = '0;
    idle;
    step;
    preload(14'd4,  32'h11223344);
    preload(14'd8,  32'h12345678);
    preload(14'd12, 32'hCAFEF00D);
    preload(14'd16, 32'h00000000);
    settle;
    check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("rst_hresp", {31'h0, HRESP}, 32'h0);
    check("rst_wea", {28'h0, ram_wea}, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    step;
    HRESETn = 1'b1;
    settle;
    check("idle_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("idle_wea", {28'h0, ram_wea}, 32'h0);

    // word write then read of a different word
    bus(1'b1, 32'h10, 3'd2);
    step;
    HWDATA = 32'hDEADBEEF;
    bus(1'b0, 32'h20, 3'd2);
    settle;
    check("wr_wea", {28'h0, ram_wea}, 32'hF);
    check("wr_addra", {18'h0, ram_addra}, 32'h4);
    check("wr_dina", ram_dina, 32'hDEADBEEF);
    check("wr_ready", {31'h0, HREADYOUT}, 32'h1);
    step;
    idle;
    settle;
    check("rd_hrdata", HRDATA, 32'h12345678);
    check("rd_ready", {31'h0, HREADYOUT}, 32'h1);
    check("mem_word4", mem[4], 32'hDEADBEEF);

    // byte and half writes, then word read after an idle cycle
    bus(1'b1, 32'h13, 3'd0);
    step;
    HWDATA = 32'hAA000000;
    bus(1'b1, 32'h12, 3'd1);
    settle;
    check("byte_wea", {28'h0, ram_wea}, 32'h8);
    step;
    HWDATA = 32'h55550000;
    idle;
    settle;
    check("half_wea", {28'h0, ram_wea}, 32'hC);
    step;
    bus(1'b0, 32'h10, 3'd2);
    step;
    idle;
    settle;
    check("bh_hrdata", HRDATA, 32'h5555BEEF);

    // read-after-write hazard on the same word
    bus(1'b1, 32'h41, 3'd0);
    step;
    HWDATA = 32'h00007F00;
    bus(1'b0, 32'h40, 3'd2);
    settle;
    check("haz_wea", {28'h0, ram_wea}, 32'h2);
    step;
    idle;
    settle;
    waits = 0;
    while (!HREADYOUT && waits < 4) begin
      waits++;
      step;
      settle;
    end
    check("haz_hrdata", HRDATA, 32'h00007F00);
`ifdef BRAM_RAW_FWD_EN
    check("haz_waits", waits, 32'd0);
`else
    check("haz_waits", waits, 32'd1);
`endif
    step;

    // unaligned word write -> two-cycle error, then aligned read in ERR2
    bus(1'b1, 32'h22, 3'd2);
    step;
    HWDATA = 32'hFFFFFFFF;
    idle;
    settle;
    check("err1_ready", {31'h0, HREADYOUT}, 32'h0);
    check("err1_resp", {31'h0, HRESP}, 32'h1);
    check("err1_wea", {28'h0, ram_wea}, 32'h0);
    step;
    bus(1'b0, 32'h20, 3'd2);
    settle;
    check("err2_ready", {31'h0, HREADYOUT}, 32'h1);
    check("err2_resp", {31'h0, HRESP}, 32'h1);
    check("err2_wea", {28'h0, ram_wea}, 32'h0);
    step;
    idle;
    settle;
    check("post_err_hrdata", HRDATA, 32'h12345678);
    check("post_err_resp", {31'h0, HRESP}, 32'h0);
    check("err_mem8", mem[8], 32'h12345678);

    // reset asserted during a write data phase
    bus(1'b1, 32'h30, 3'd2);
    step;
    HWDATA = 32'hFFFFFFFF;
    idle;
    settle;
    check("mid_wea_before", {28'h0, ram_wea}, 32'hF);
    #2;
    HRESETn = 1'b0;
    #1;
    check("mid_wea", {28'h0, ram_wea}, 32'h0);
    check("mid_ready", {31'h0, HREADYOUT}, 32'h1);
    step;
    HRESETn = 1'b1;
    bus(1'b0, 32'h30, 3'd2);
    step;
    idle;
    settle;
    check("mid_readback", HRDATA, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
